// File: rtl/cell_draw_ctrl.sv
// Draws one 16x12 map cell on the LCD: window commands (CASET/PASET/RAMWR) followed by
// a solid RGB565 fill, then pulses cmd_done back to the image generator.
module cell_draw_ctrl #(
  parameter int          CELL_W   = 10,
  parameter int          CELL_H   = 10,
  parameter logic [15:0] X_OFFSET = 16'd0,
  parameter logic [15:0] Y_OFFSET = 16'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_update,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  input  logic       lcd_ready,
  output logic       lcd_valid,
  output logic       lcd_dc,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       cmd_done,
  output logic       err,
  output logic [3:0] state_dbg
);

  // LCD handshake: a byte moves on a posedge where lcd_valid & lcd_ready. Once lcd_valid
  // is raised, lcd_dc/lcd_data stay stable and lcd_valid stays high until that transfer.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CASET_C  = 4'd1,
    S_CASET_D  = 4'd2,
    S_PASET_C  = 4'd3,
    S_PASET_D  = 4'd4,
    S_RAMWR_C  = 4'd5,
    S_PIXEL    = 4'd6,
    S_DONE     = 4'd7,
    S_REJ_WAIT = 4'd8,
    S_REJECT   = 4'd9
  } state_t;

  localparam int          NPIX     = CELL_W * CELL_H;
  localparam logic [7:0]  PIX_LAST = 8'(NPIX - 1);
  localparam logic [15:0] W_M1     = 16'(CELL_W - 1);
  localparam logic [15:0] H_M1     = 16'(CELL_H - 1);

  state_t      state, state_nxt;
  logic [3:0]  x_q, y_q;
  logic [2:0]  obj_q;
  logic [1:0]  byte_idx;
  logic [7:0]  pix_cnt;
  logic        lo_q;
  logic        xfer;
  logic        req_bad;
  logic [15:0] xs, xe, ys, ye;
  logic [15:0] colour;

  assign xfer      = lcd_valid & lcd_ready;
  assign req_bad   = (y > 4'd11) | (obj_code > 3'd4);
  assign state_dbg = state;

  assign xs = X_OFFSET + 16'(x_q) * 16'(CELL_W);
  assign xe = xs + W_M1;
  assign ys = Y_OFFSET + 16'(y_q) * 16'(CELL_H);
  assign ye = ys + H_M1;

  always_comb begin
    colour = 16'h0000;
    case (obj_q)
      3'd1:    colour = 16'h07E0;
      3'd2:    colour = 16'h03E0;
      3'd3:    colour = 16'hF800;
      3'd4:    colour = 16'h7BEF;
      default: colour = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Counters only move on a transfer, which is what keeps the presented byte stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= 4'd0;
      y_q      <= 4'd0;
      obj_q    <= 3'd0;
      byte_idx <= 2'd0;
      pix_cnt  <= 8'd0;
      lo_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_update) begin
            x_q      <= x;
            y_q      <= y;
            obj_q    <= obj_code;
            byte_idx <= 2'd0;
            pix_cnt  <= 8'd0;
            lo_q     <= 1'b0;
          end
        end
        S_CASET_D, S_PASET_D: begin
          if (xfer) byte_idx <= byte_idx + 2'd1;
        end
        S_PIXEL: begin
          if (xfer) begin
            lo_q <= ~lo_q;
            if (lo_q) pix_cnt <= pix_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (en_update) state_nxt = req_bad ? S_REJ_WAIT : S_CASET_C;
      S_CASET_C:  if (xfer) state_nxt = S_CASET_D;
      S_CASET_D:  if (xfer && byte_idx == 2'd3) state_nxt = S_PASET_C;
      S_PASET_C:  if (xfer) state_nxt = S_PASET_D;
      S_PASET_D:  if (xfer && byte_idx == 2'd3) state_nxt = S_RAMWR_C;
      S_RAMWR_C:  if (xfer) state_nxt = S_PIXEL;
      S_PIXEL:    if (xfer && lo_q && pix_cnt == PIX_LAST) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      S_REJ_WAIT: state_nxt = S_REJECT;
      S_REJECT:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lcd_valid = 1'b0;
    lcd_dc    = 1'b0;
    lcd_data  = 8'h00;
    busy      = (state != S_IDLE);
    cmd_done  = 1'b0;
    err       = 1'b0;
    case (state)
      S_CASET_C: begin
        lcd_valid = 1'b1;
        lcd_data  = 8'h2A;
      end
      S_CASET_D: begin
        lcd_valid = 1'b1;
        lcd_dc    = 1'b1;
        case (byte_idx)
          2'd0:    lcd_data = xs[15:8];
          2'd1:    lcd_data = xs[7:0];
          2'd2:    lcd_data = xe[15:8];
          default: lcd_data = xe[7:0];
        endcase
      end
      S_PASET_C: begin
        lcd_valid = 1'b1;
        lcd_data  = 8'h2B;
      end
      S_PASET_D: begin
        lcd_valid = 1'b1;
        lcd_dc    = 1'b1;
        case (byte_idx)
          2'd0:    lcd_data = ys[15:8];
          2'd1:    lcd_data = ys[7:0];
          2'd2:    lcd_data = ye[15:8];
          default: lcd_data = ye[7:0];
        endcase
      end
      S_RAMWR_C: begin
        lcd_valid = 1'b1;
        lcd_data  = 8'h2C;
      end
      S_PIXEL: begin
        lcd_valid = 1'b1;
        lcd_dc    = 1'b1;
        lcd_data  = lo_q ? colour[7:0] : colour[15:8];
      end
      S_DONE:   cmd_done = 1'b1;
      S_REJECT: begin
        cmd_done = 1'b1;
        err      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cell_draw_ctrl.sv
// Directed bench for cell_draw_ctrl: table of cell requests with hand-computed window
// bytes and colours, plus sequences for mid-transfer requests and reset abort.
module tb_cell_draw_ctrl;

  localparam int NPIX = 100;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_update = 1'b0;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;
  logic [2:0] obj_code = 3'd0;
  logic       lcd_ready = 1'b1;
  logic       lcd_valid, lcd_dc, busy, cmd_done, err;
  logic [7:0] lcd_data;
  logic [3:0] state_dbg;

  cell_draw_ctrl dut (
    .clk(tb_clk), .rst(rst), .en_update(en_update), .x(x), .y(y), .obj_code(obj_code),
    .lcd_ready(lcd_ready), .lcd_valid(lcd_valid), .lcd_dc(lcd_dc), .lcd_data(lcd_data),
    .busy(busy), .cmd_done(cmd_done), .err(err), .state_dbg(state_dbg)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct packed {
    logic [3:0]  x;
    logic [3:0]  y;
    logic [2:0]  obj;
    logic        rnd;
    logic        err;
    logic [63:0] hdr;
    logic [15:0] col;
  } vec_t;

  vec_t       vecs[8];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int stall_cnt = 0;
  logic rand_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_byte = 9'd0;

  always @(posedge tb_clk) cyc <= cyc + 1;

  always begin
    @(posedge tb_clk);
    #1;
    if (rand_ready) lcd_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Monitor: samples mid-cycle, records transfers, pulses and stall stability.
  always @(negedge tb_clk) begin
    if (!rst) begin
      if (lcd_valid && lcd_ready) got_q.push_back({lcd_dc, lcd_data});
      if (lcd_valid && !lcd_ready) stall_cnt++;
      if (cmd_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) begin
        err_cnt++;
        chk("err_with_done", 32'(cmd_done), 32'd1);
      end
    end
    if (prev_stall) begin
      chk("stall_valid_held", 32'(lcd_valid), 32'd1);
      chk("stall_byte_held", 32'({lcd_dc, lcd_data}), 32'(prev_byte));
    end
    prev_stall = !rst && lcd_valid && !lcd_ready;
    prev_byte  = {lcd_dc, lcd_data};
  end

  task automatic build_exp(input vec_t v);
    exp_q.delete();
    if (v.err) return;
    exp_q.push_back(9'h02A);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, v.hdr[63-8*i -: 8]});
    exp_q.push_back(9'h02B);
    for (int i = 4; i < 8; i++) exp_q.push_back({1'b1, v.hdr[63-8*i -: 8]});
    exp_q.push_back(9'h02C);
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back({1'b1, v.col[15:8]});
      exp_q.push_back({1'b1, v.col[7:0]});
    end
  endtask

  // Caller must be at posedge+#1 with the DUT idle.
  task automatic start_req(input vec_t v);
    got_q.delete();
    done_cnt  = 0;
    err_cnt   = 0;
    stall_cnt = 0;
    build_exp(v);
    rand_ready = v.rnd;
    if (!v.rnd) lcd_ready = 1'b1;
    x = v.x;
    y = v.y;
    obj_code = v.obj;
    en_update = 1'b1;
    @(posedge tb_clk);
    #1;
    en_update = 1'b0;
    req_cyc = cyc;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int settle);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge tb_clk);
      n++;
    end
    chk("done_timeout", 32'(done_cnt != 0), 32'd1);
    repeat (settle) @(posedge tb_clk);
    #1;
  endtask

  task automatic check_result(input vec_t v, input string tag);
    int lat_exp;
    int nb;
    rand_ready = 1'b0;
    lat_exp = v.err ? 1 : (11 + 2 * NPIX + stall_cnt);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err_count"}, 32'(err_cnt), 32'(v.err));
    chk({tag, "_latency"}, 32'(done_cyc - req_cyc), 32'(lat_exp));
    chk({tag, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++) chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(posedge tb_clk);
    #1;
    start_req(v);
    wait_done(4);
    check_result(v, tag);
  endtask

  initial begin
    vec_t t5, v6a, v6b;
    vecs[0] = '{x:4'd4,  y:4'd4,  obj:3'd1, rnd:1'b0, err:1'b0, hdr:64'h0028_0031_0028_0031, col:16'h07E0};
    vecs[1] = '{x:4'd15, y:4'd11, obj:3'd4, rnd:1'b1, err:1'b0, hdr:64'h0096_009F_006E_0077, col:16'h7BEF};
    vecs[2] = '{x:4'd0,  y:4'd0,  obj:3'd0, rnd:1'b0, err:1'b0, hdr:64'h0000_0009_0000_0009, col:16'h0000};
    vecs[3] = '{x:4'd7,  y:4'd2,  obj:3'd2, rnd:1'b1, err:1'b0, hdr:64'h0046_004F_0014_001D, col:16'h03E0};
    vecs[4] = '{x:4'd3,  y:4'd9,  obj:3'd3, rnd:1'b0, err:1'b0, hdr:64'h001E_0027_005A_0063, col:16'hF800};
    vecs[5] = '{x:4'd2,  y:4'd12, obj:3'd1, rnd:1'b0, err:1'b1, hdr:64'h0, col:16'h0};
    vecs[6] = '{x:4'd2,  y:4'd3,  obj:3'd5, rnd:1'b0, err:1'b1, hdr:64'h0, col:16'h0};
    vecs[7] = '{x:4'd15, y:4'd15, obj:3'd7, rnd:1'b1, err:1'b1, hdr:64'h0, col:16'h0};
    t5  = '{x:4'd1, y:4'd1, obj:3'd3, rnd:1'b0, err:1'b0, hdr:64'h000A_0013_000A_0013, col:16'hF800};
    v6a = '{x:4'd5, y:4'd6, obj:3'd1, rnd:1'b0, err:1'b0, hdr:64'h0032_003B_003C_0045, col:16'h07E0};
    v6b = '{x:4'd6, y:4'd0, obj:3'd2, rnd:1'b0, err:1'b0, hdr:64'h003C_0045_0000_0009, col:16'h03E0};

    // Reset state, then quiet idle.
    repeat (2) @(posedge tb_clk);
    #1;
    chk("rst_lcd_valid", 32'(lcd_valid), 32'd0);
    chk("rst_lcd_dc", 32'(lcd_dc), 32'd0);
    chk("rst_lcd_data", 32'(lcd_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_done", 32'(cmd_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge tb_clk);
      #1;
      chk("idle_no_valid", 32'({lcd_valid, busy, cmd_done}), 32'd0);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Request re-pulsed mid-PIXEL is ignored; next request accepted right after cmd_done.
    @(posedge tb_clk);
    #1;
    start_req(t5);
    for (int n = 0; n < 200 && got_q.size() < 40; n++) @(posedge tb_clk);
    #1;
    chk("t5_in_pixel", 32'(state_dbg), 32'd6);
    x = 4'd9;
    y = 4'd5;
    obj_code = 3'd1;
    en_update = 1'b1;
    @(posedge tb_clk);
    #1;
    en_update = 1'b0;
    wait_done(0);
    check_result(t5, "t5");
    start_req(vecs[0]);
    wait_done(4);
    check_result(vecs[0], "t5_next");

    // Reset while stalled in PIXEL aborts silently; next request starts from 0x2A.
    @(posedge tb_clk);
    #1;
    start_req(v6a);
    for (int n = 0; n < 200 && got_q.size() < 30; n++) @(posedge tb_clk);
    #1;
    lcd_ready = 1'b0;
    repeat (3) @(posedge tb_clk);
    #1;
    chk("t6_stalled_pixel", 32'({state_dbg, lcd_valid}), 32'({4'd6, 1'b1}));
    rst = 1'b1;
    @(posedge tb_clk);
    #1;
    chk("t6_abort_valid", 32'(lcd_valid), 32'd0);
    chk("t6_abort_busy", 32'(busy), 32'd0);
    chk("t6_abort_done", 32'(cmd_done), 32'd0);
    rst = 1'b0;
    lcd_ready = 1'b1;
    repeat (5) @(posedge tb_clk);
    #1;
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    run_vec(v6b, "t6_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
